// File: rtl/syscall_responder.sv
// rtl/syscall_responder.sv - WB-stage syscall responder: print int/hex, exit, tick-timed display hold
// Optional macro SYSCALL_STATS_EN adds the serviced-syscall counter on sys_count.
module syscall_responder #(
    parameter int HOLD_TICKS     = 4,
    parameter int CODE_PRINT_INT = 1,
    parameter int CODE_EXIT      = 10,
    parameter int CODE_PRINT_HEX = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        sys_req,
    input  logic [31:0] sys_v0,
    input  logic [31:0] sys_a0,
    output logic        sys_ack,
    output logic        stall,
    output logic        halted,
    output logic [31:0] display,
    output logic        disp_hex,
    output logic        err_code,
    output logic [15:0] sys_count
);

    localparam int CW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        HOLD,
        ACK,
        WAIT_LOW,
        HALT
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [31:0]     v0_q;
    logic [31:0]     a0_q;
    logic [CW-1:0]   hold_cnt;
    logic            is_print;
    logic            is_hex;
    logic            is_exit;
    logic            hold_done;

    assign is_hex    = (v0_q == 32'(CODE_PRINT_HEX));
    assign is_print  = (v0_q == 32'(CODE_PRINT_INT)) || is_hex;
    assign is_exit   = (v0_q == 32'(CODE_EXIT));
    assign hold_done = tick && (32'(hold_cnt) + 32'd1 == 32'(HOLD_TICKS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (sys_req) next_state = DECODE;
            end
            DECODE: begin
                if (is_exit) begin
                    next_state = HALT;
                end else if (is_print && (HOLD_TICKS > 0)) begin
                    next_state = HOLD;
                end else begin
                    next_state = ACK;
                end
            end
            HOLD: begin
                if (hold_done) next_state = ACK;
            end
            ACK:      next_state = WAIT_LOW;
            WAIT_LOW: begin
                if (!sys_req) next_state = IDLE;
            end
            HALT:     next_state = HALT;
            default:  next_state = IDLE;
        endcase
    end

    // ACK and WAIT_LOW release the pipeline so WB retires while ack is high.
    always_comb begin
        sys_ack = (state == ACK);
        stall   = ((state == IDLE) && sys_req) || (state == DECODE) ||
                  (state == HOLD) || (state == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q     <= '0;
            a0_q     <= '0;
            hold_cnt <= '0;
            halted   <= 1'b0;
            display  <= '0;
            disp_hex <= 1'b0;
            err_code <= 1'b0;
        end else begin
            if (state == IDLE && sys_req) begin
                v0_q <= sys_v0;
                a0_q <= sys_a0;
            end
            // Outside HOLD the counter sits at zero, so every HOLD entry starts fresh.
            if (state != HOLD) begin
                hold_cnt <= '0;
            end else if (tick) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (state == DECODE) begin
                if (is_print) begin
                    display  <= a0_q;
                    disp_hex <= is_hex;
                end else if (is_exit) begin
                    halted <= 1'b1;
                end else begin
                    err_code <= 1'b1;
                end
            end
        end
    end

`ifdef SYSCALL_STATS_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (((state == ACK) || (state == DECODE && is_exit)) &&
                     (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign sys_count = count_q;
`else
    assign sys_count = '0;
`endif

endmodule

// File: tb/tb_syscall_responder.sv
// tb/tb_syscall_responder.sv - randomized self-checking bench for syscall_responder
// Two instances (HOLD_TICKS=0 and 4) share clk/rst/tick; each has its own request port.
module tb_syscall_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        req       [2];
    logic [31:0] v0        [2];
    logic [31:0] a0        [2];
    logic        ack       [2];
    logic        stall     [2];
    logic        halted    [2];
    logic [31:0] display   [2];
    logic        disp_hex  [2];
    logic        err_code  [2];
    logic [15:0] sys_count [2];

    always #5 clk = ~clk;

    syscall_responder #(.HOLD_TICKS(0)) u_h0 (
        .clk(clk), .rst(rst), .tick(tick),
        .sys_req(req[0]), .sys_v0(v0[0]), .sys_a0(a0[0]),
        .sys_ack(ack[0]), .stall(stall[0]), .halted(halted[0]),
        .display(display[0]), .disp_hex(disp_hex[0]),
        .err_code(err_code[0]), .sys_count(sys_count[0])
    );

    syscall_responder #(.HOLD_TICKS(4)) u_h4 (
        .clk(clk), .rst(rst), .tick(tick),
        .sys_req(req[1]), .sys_v0(v0[1]), .sys_a0(a0[1]),
        .sys_ack(ack[1]), .stall(stall[1]), .halted(halted[1]),
        .display(display[1]), .disp_hex(disp_hex[1]),
        .err_code(err_code[1]), .sys_count(sys_count[1])
    );

    int checks = 0;
    int errors = 0;
    int hold_of [2] = '{0, 4};

    logic [31:0] m_disp  [2];
    logic        m_hex   [2];
    logic        m_err   [2];
    logic        m_halt  [2];
    int          m_count [2];
    int          tick_mode;
    int          tick_phase = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_count(input int s);
`ifdef SYSCALL_STATS_EN
        return (m_count[s] > 65535) ? 16'hFFFF : 16'(m_count[s]);
`else
        return 16'd0;
`endif
    endfunction

    // Advance to just after the next rising edge and choose this cycle's tick.
    task automatic drive_cycle();
        @(posedge clk);
        #1;
        tick_phase++;
        case (tick_mode)
            0:       tick = ($urandom_range(0, 3) == 0);
            1:       tick = ((tick_phase % 10) == 9);
            default: tick = 1'b0;
        endcase
    endtask

    task automatic check_state(input int s, input string tag);
        check({tag, "_display"}, display[s], m_disp[s]);
        check({tag, "_hex"}, 32'(disp_hex[s]), 32'(m_hex[s]));
        check({tag, "_err"}, 32'(err_code[s]), 32'(m_err[s]));
        check({tag, "_halted"}, 32'(halted[s]), 32'(m_halt[s]));
        check({tag, "_count"}, 32'(sys_count[s]), 32'(exp_count(s)));
    endtask

    task automatic do_reset();
        drive_cycle();
        rst = 1'b1;
        for (int s = 0; s < 2; s++) req[s] = 1'b0;
        drive_cycle();
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            m_disp[s]  = '0;
            m_hex[s]   = 1'b0;
            m_err[s]   = 1'b0;
            m_halt[s]  = 1'b0;
            m_count[s] = 0;
        end
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_ack", 32'(ack[s]), 0);
            check("rst_stall", 32'(stall[s]), 0);
            check_state(s, "rst");
        end
    endtask

    // One request on instance s; linger keeps req high after the ack with a fresh payload.
    task automatic syscall(input int s, input logic [31:0] code, input logic [31:0] arg,
                           input int linger);
        bit is_print = (code == 32'd1) || (code == 32'd34);
        bit is_exit  = (code == 32'd10);
        bit svc      = !m_halt[s];
        bit acks     = svc && !is_exit;
        int due      = -1;
        int ticks    = 0;
        bit done     = 1'b0;

        drive_cycle();
        req[s] = 1'b1;
        v0[s]  = code;
        a0[s]  = arg;
        @(negedge clk);
        check("req_stall", 32'(stall[s]), 1);
        check("req_ack", 32'(ack[s]), 0);
        if (acks && !(is_print && hold_of[s] > 0)) due = 2;

        for (int k = 1; k <= 120 && !done; k++) begin
            drive_cycle();
            v0[s] = $urandom;
            a0[s] = $urandom;
            if (acks && is_print && hold_of[s] > 0 && k >= 2 && tick && due < 0) begin
                ticks++;
                if (ticks == hold_of[s]) due = k + 1;
            end
            @(negedge clk);
            if (k == 2 && svc) begin
                if (is_print) begin
                    m_disp[s] = arg;
                    m_hex[s]  = (code == 32'd34);
                end else if (is_exit) begin
                    m_halt[s] = 1'b1;
                    m_count[s]++;
                end else begin
                    m_err[s] = 1'b1;
                end
                check_state(s, "decode");
            end
            check("ack", 32'(ack[s]), 32'(k == due));
            check("stall", 32'(stall[s]), 32'(due < 0 || k < due));
            if (k == due) begin
                check_state(s, "ackcyc");
                m_count[s]++;
                done = 1'b1;
            end else if (!acks && k == 8) begin
                done = 1'b1;
            end
        end
        if (!done) check("ack_timeout", 0, 1);

        for (int i = 0; i < linger; i++) begin
            drive_cycle();
            v0[s] = 32'd1;
            a0[s] = ~arg;
            @(negedge clk);
            check("linger_ack", 32'(ack[s]), 0);
            check("linger_stall", 32'(stall[s]), 32'(!acks));
        end
        drive_cycle();
        req[s] = 1'b0;
        @(negedge clk);
        check("drop_ack", 32'(ack[s]), 0);
        check("drop_stall", 32'(stall[s]), 32'(m_halt[s]));
        drive_cycle();
        @(negedge clk);
        check("idle_stall", 32'(stall[s]), 32'(m_halt[s]));
        check_state(s, "end");
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        tick_mode = 2;
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0;
            v0[s]  = '0;
            a0[s]  = '0;
        end
        do_reset();

        // Directed: zero-hold decimal print, hex hold on 10-cycle ticks, unsupported code.
        tick_mode = 0;
        syscall(0, 32'd1, 32'd1234, 0);
        tick_mode = 1;
        syscall(1, 32'd34, 32'hDEADBEEF, 0);
        tick_mode = 0;
        syscall(0, 32'd7, 32'h55, 2);
        syscall(1, 32'd7, 32'h66, 1);

        // Exit is terminal; later requests are ignored until reset.
        syscall(0, 32'd10, 32'd0, 0);
        syscall(0, 32'd1, 32'd5, 0);
        do_reset();

        // Reset in the middle of a hold after two counted ticks.
        tick_mode = 2;
        drive_cycle();
        req[1] = 1'b1;
        v0[1]  = 32'd1;
        a0[1]  = 32'd99;
        repeat (2) drive_cycle();
        drive_cycle();
        tick = 1'b1;
        @(negedge clk);
        check("midhold_stall", 32'(stall[1]), 1);
        check("midhold_display", display[1], 32'd99);
        drive_cycle();
        tick = 1'b1;
        @(negedge clk);
        check("midhold_ack", 32'(ack[1]), 0);
        drive_cycle();
        rst    = 1'b1;
        req[1] = 1'b0;
        drive_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ack", 32'(ack[1]), 0);
        check("midrst_stall", 32'(stall[1]), 0);
        check("midrst_display", display[1], 0);
        check("midrst_halted", 32'(halted[1]), 0);
        check("midrst_count", 32'(sys_count[1]), 0);
        do_reset();

        // Counter: three prints then exit.
        tick_mode = 0;
        syscall(0, 32'd1, 32'd11, 0);
        syscall(0, 32'd34, 32'hABCD, 0);
        syscall(0, 32'd1, 32'd22, 0);
        syscall(0, 32'd10, 32'd0, 0);
        check("stats_four", 32'(sys_count[0]), 32'(exp_count(0)));
        do_reset();

        // Randomized mix of print and unsupported codes on both instances.
        for (int n = 0; n < 40; n++) begin
            int s;
            int r;
            logic [31:0] code;
            s = $urandom_range(0, 1);
            r = $urandom_range(0, 3);
            code = $urandom;
            if (r == 0) code = 32'd1;
            else if (r == 1) code = 32'd34;
            else if (code == 32'd1 || code == 32'd10 || code == 32'd34) code = 32'd7;
            syscall(s, code, $urandom, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
